// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit: funct3 condition encodings,
// resolve FSM states, predictor reset value and statistics counter width.
package branch_pkg;

  localparam logic [2:0] Funct3Beq  = 3'b000;
  localparam logic [2:0] Funct3Bne  = 3'b001;
  localparam logic [2:0] Funct3Blt  = 3'b100;
  localparam logic [2:0] Funct3Bge  = 3'b101;
  localparam logic [2:0] Funct3Bltu = 3'b110;
  localparam logic [2:0] Funct3Bgeu = 3'b111;

  // Weakly not taken.
  localparam logic [1:0] BhtResetVal = 2'b01;

  localparam int unsigned CntWidth = 32;

  typedef enum logic {
    StIdle,
    StFlush
  } bpu_state_e;

  // 010 and 011 are the only unassigned branch conditions.
  function automatic logic funct3_is_illegal(input logic [2:0] funct3);
    return funct3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bundle between fetch/execute and the branch predict unit.
//   pred_pc/pred_taken         : prediction lookup
//   res_* with res_valid/ready : resolve request handshake
//   out_valid .. flush         : registered resolve result
//   br_count, mispred_count    : saturating statistics
// master = requester side, slave = branch_predict_unit side.
interface branch_predict_unit_if import branch_pkg::*; #(
  parameter int unsigned XLEN = 64
) ();

  logic [XLEN-1:0]     pred_pc;
  logic                pred_taken;

  logic                res_valid;
  logic                res_ready;
  logic                res_branch;
  logic [2:0]          res_funct3;
  logic [XLEN-1:0]     res_a;
  logic [XLEN-1:0]     res_b;
  logic [XLEN-1:0]     res_pc;
  logic [XLEN-1:0]     res_imm;
  logic                res_pred_taken;

  logic                out_valid;
  logic                to_branch;
  logic [XLEN-1:0]     target;
  logic                mispredict;
  logic                illegal_br;
  logic                flush;
  logic [CntWidth-1:0] br_count;
  logic [CntWidth-1:0] mispred_count;

  modport master (
    output pred_pc, res_valid, res_branch, res_funct3, res_a, res_b, res_pc, res_imm,
           res_pred_taken,
    input  pred_taken, res_ready, out_valid, to_branch, target, mispredict, illegal_br,
           flush, br_count, mispred_count
  );

  modport slave (
    input  pred_pc, res_valid, res_branch, res_funct3, res_a, res_b, res_pc, res_imm,
           res_pred_taken,
    output pred_taken, res_ready, out_valid, to_branch, target, mispredict, illegal_br,
           flush, br_count, mispred_count
  );

endinterface

// File: rtl/bht_table.sv
// Branch history table of 2-bit saturating counters.
//   rd_idx/rd_taken : combinational lookup, returns entry MSB
//   wr_en/wr_idx/wr_taken : synchronous saturating inc (taken) or dec
// A read of the index being written returns the pre-update value.
module bht_table import branch_pkg::*; #(
  parameter int unsigned Depth = 16,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IdxW-1:0] rd_idx,
  output logic            rd_taken,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_idx,
  input  logic            wr_taken
);

  logic [1:0] tbl_q [Depth];
  logic [1:0] cur;
  logic [1:0] nxt;

  always_comb begin
    cur = tbl_q[wr_idx];
    nxt = cur;
    if (wr_taken && cur != 2'b11) begin
      nxt = cur + 2'd1;
    end else if (!wr_taken && cur != 2'b00) begin
      nxt = cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        tbl_q[i] <= BhtResetVal;
      end
    end else if (wr_en) begin
      tbl_q[wr_idx] <= nxt;
    end
  end

  assign rd_taken = tbl_q[rd_idx][1];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BHT-based direction prediction plus branch resolution.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of branch_predict_unit_if (lookup, resolve, result, stats)
// A resolve is accepted when res_valid && res_ready; the result appears one cycle
// later. A mispredicting branch stalls resolution for FLUSH_CYCLES cycles.
module branch_predict_unit import branch_pkg::*; #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned BHT_DEPTH    = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);
  localparam int unsigned FcW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0] FlushLast = FcW'(FLUSH_CYCLES - 1);

  bpu_state_e state_q, state_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic ready_q;

  logic accept, legal, cond_taken, taken, misp;
  logic [XLEN-1:0] target_d;

  logic out_valid_q, to_branch_q, mispredict_q, illegal_q, flush_q;
  logic [XLEN-1:0] target_q;
  logic [CntWidth-1:0] br_cnt_q, mispred_cnt_q;

  logic unused_pred_pc;
  assign unused_pred_pc = ^{bus.pred_pc[XLEN-1:IdxW+2], bus.pred_pc[1:0]};

  // ready_q keeps res_ready low during reset and until the first edge after release.
  assign bus.res_ready = ready_q && (state_q == StIdle);
  assign accept        = bus.res_valid && bus.res_ready;

  always_comb begin
    cond_taken = 1'b0;
    case (bus.res_funct3)
      Funct3Beq:  cond_taken = bus.res_a == bus.res_b;
      Funct3Bne:  cond_taken = bus.res_a != bus.res_b;
      Funct3Blt:  cond_taken = $signed(bus.res_a) <  $signed(bus.res_b);
      Funct3Bge:  cond_taken = $signed(bus.res_a) >= $signed(bus.res_b);
      Funct3Bltu: cond_taken = bus.res_a <  bus.res_b;
      Funct3Bgeu: cond_taken = bus.res_a >= bus.res_b;
      default:    cond_taken = 1'b0;
    endcase
  end

  // Illegal conditions and non-branches never mispredict, count or train.
  assign legal    = bus.res_branch && !funct3_is_illegal(bus.res_funct3);
  assign taken    = legal && cond_taken;
  assign misp     = legal && (taken != bus.res_pred_taken);
  assign target_d = taken ? bus.res_pc + bus.res_imm : bus.res_pc + XLEN'(4);

  bht_table #(
    .Depth (BHT_DEPTH)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (bus.pred_pc[IdxW+1:2]),
    .rd_taken (bus.pred_taken),
    .wr_en    (accept && legal),
    .wr_idx   (bus.res_pc[IdxW+1:2]),
    .wr_taken (taken)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && misp) begin
          state_d = StFlush;
          fcnt_d  = '0;
        end
      end
      StFlush: begin
        if (fcnt_q == FlushLast) begin
          state_d = StIdle;
        end else begin
          fcnt_d = fcnt_q + FcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      fcnt_q        <= '0;
      ready_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      flush_q       <= 1'b0;
      to_branch_q   <= 1'b0;
      target_q      <= '0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      ready_q     <= 1'b1;
      out_valid_q <= accept;
      flush_q     <= accept && misp;
      if (accept) begin
        to_branch_q  <= taken;
        target_q     <= target_d;
        mispredict_q <= misp;
        illegal_q    <= bus.res_branch && funct3_is_illegal(bus.res_funct3);
        if (legal && br_cnt_q != '1) begin
          br_cnt_q <= br_cnt_q + 1'b1;
        end
        if (misp && mispred_cnt_q != '1) begin
          mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.flush         = flush_q;
  assign bus.to_branch     = to_branch_q;
  assign bus.target        = target_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.illegal_br    = illegal_q;
  assign bus.br_count      = br_cnt_q;
  assign bus.mispred_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (XLEN=64, 16 entries, 2 flush cycles).
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(64)) bus ();

  branch_predict_unit #(
    .XLEN         (64),
    .BHT_DEPTH    (16),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        tb;
    logic [63:0] tgt;
    logic        misp;
    logic        ill;
    logic [31:0] brc;
    logic [31:0] mpc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop = 0;

  logic [1:0]  bht_m [16];
  logic [31:0] brc_m;
  logic [31:0] mpc_m;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_m(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_m(input logic [63:0] pc);
    return int'(pc[5:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
    brc_m = '0;
    mpc_m = '0;
  endtask

  // Drive one resolve request, push its expected result, check pred_taken before
  // and after the update of the same index.
  task automatic do_res(input logic br, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] pc, input logic [63:0] imm,
                        input logic pt);
    exp_t e;
    logic lg;
    logic tk;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_ready) check_eq("ready_timeout", 64'(bus.res_ready), 64'd1);
    bus.res_valid = 1'b1;
    bus.res_branch = br;
    bus.res_funct3 = f3;
    bus.res_a = a;
    bus.res_b = b;
    bus.res_pc = pc;
    bus.res_imm = imm;
    bus.res_pred_taken = pt;
    bus.pred_pc = pc;
    lg = br && (f3 != 3'b010) && (f3 != 3'b011);
    tk = lg && cond_m(f3, a, b);
    e.tb = tk;
    e.tgt = tk ? pc + imm : pc + 64'd4;
    e.misp = lg && (tk != pt);
    e.ill = br && !lg;
    if (lg && brc_m != 32'hFFFF_FFFF) brc_m++;
    if (e.misp && mpc_m != 32'hFFFF_FFFF) mpc_m++;
    e.brc = brc_m;
    e.mpc = mpc_m;
    sb.push_back(e);
    n_push++;
    #1 check_eq("pred_old", 64'(bus.pred_taken), 64'(bht_m[idx_m(pc)][1]));
    @(posedge clk);
    #1 bus.res_valid = 1'b0;
    if (lg) begin
      if (tk && bht_m[idx_m(pc)] != 2'b11) bht_m[idx_m(pc)]++;
      else if (!tk && bht_m[idx_m(pc)] != 2'b00) bht_m[idx_m(pc)]--;
    end
    @(negedge clk);
    check_eq("pred_new", 64'(bus.pred_taken), 64'(bht_m[idx_m(pc)][1]));
  endtask

  // Scoreboard: compare every out_valid pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.flush && !bus.out_valid) check_eq("flush_no_valid", 64'(bus.flush), 64'd0);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          n_pop++;
          check_eq("to_branch", 64'(bus.to_branch), 64'(e.tb));
          check_eq("target", bus.target, e.tgt);
          check_eq("mispredict", 64'(bus.mispredict), 64'(e.misp));
          check_eq("flush", 64'(bus.flush), 64'(e.misp));
          check_eq("illegal_br", 64'(bus.illegal_br), 64'(e.ill));
          check_eq("br_count", 64'(bus.br_count), 64'(e.brc));
          check_eq("mispred_count", 64'(bus.mispred_count), 64'(e.mpc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [6];
    f3_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    model_reset();
    bus.pred_pc = 64'h200;
    bus.res_valid = 1'b0;
    bus.res_branch = 1'b0;
    bus.res_funct3 = 3'b000;
    bus.res_a = '0;
    bus.res_b = '0;
    bus.res_pc = '0;
    bus.res_imm = '0;
    bus.res_pred_taken = 1'b0;

    // Reset state.
    #1;
    check_eq("rst_ready", 64'(bus.res_ready), 64'd0);
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_target", bus.target, 64'd0);
    check_eq("rst_br_count", 64'(bus.br_count), 64'd0);
    check_eq("rst_pred", 64'(bus.pred_taken), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("ready_after_rst", 64'(bus.res_ready), 64'd1);

    // Signed lt mispredict, then two stall cycles.
    do_res(1'b1, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'h20, 1'b0);
    check_eq("stall0", 64'(bus.res_ready), 64'd0);
    @(negedge clk);
    check_eq("stall1", 64'(bus.res_ready), 64'd0);
    @(negedge clk);
    check_eq("stall_end", 64'(bus.res_ready), 64'd1);

    // Unsigned compares with -1 vs 1.
    do_res(1'b1, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h140, 64'h40, 1'b0);
    do_res(1'b1, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h140, 64'h40, 1'b1);
    do_res(1'b1, 3'b000, 64'd5, 64'd5, 64'h180, 64'h8, 1'b1);
    do_res(1'b1, 3'b001, 64'd5, 64'd5, 64'h184, 64'h8, 1'b0);
    do_res(1'b1, 3'b101, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'h188, 64'h8, 1'b1);

    // Training one entry: three taken, four not taken.
    for (int i = 0; i < 3; i++) do_res(1'b1, 3'b000, 64'd7, 64'd7, 64'h208, 64'h10, 1'b0);
    check_eq("pred_sat_taken", 64'(bus.pred_taken), 64'd1);
    for (int i = 0; i < 4; i++) do_res(1'b1, 3'b001, 64'd7, 64'd7, 64'h208, 64'h10, 1'b1);
    check_eq("pred_sat_nt", 64'(bus.pred_taken), 64'd0);

    // Wrap, illegal, non-branch, negative offset.
    do_res(1'b1, 3'b000, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b0);
    do_res(1'b1, 3'b011, 64'd3, 64'd3, 64'h220, 64'h40, 1'b0);
    do_res(1'b1, 3'b010, 64'd3, 64'd4, 64'h224, 64'h40, 1'b0);
    do_res(1'b0, 3'b000, 64'd3, 64'd3, 64'h300, 64'h40, 1'b1);
    do_res(1'b1, 3'b000, 64'd9, 64'd9, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);

    // Random legal branches over a small PC range.
    for (int i = 0; i < 24; i++) begin
      do_res(1'b1, f3_tab[$urandom_range(0, 5)],
             {$urandom, $urandom} >> $urandom_range(0, 63),
             {$urandom, $urandom} >> $urandom_range(0, 63),
             64'({$urandom_range(0, 63), 2'b00}), 64'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
    end

    // Reset while flushing.
    do_res(1'b1, 3'b000, 64'd1, 64'd1, 64'h2000, 64'h80, 1'b0);
    check_eq("pre_rst_pred", 64'(bus.pred_taken), 64'(bht_m[0][1]));
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_flush", 64'(bus.flush), 64'd0);
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_target", bus.target, 64'd0);
    check_eq("mid_rst_to_branch", 64'(bus.to_branch), 64'd0);
    check_eq("mid_rst_misp", 64'(bus.mispredict), 64'd0);
    check_eq("mid_rst_br_count", 64'(bus.br_count), 64'd0);
    check_eq("mid_rst_ready", 64'(bus.res_ready), 64'd0);
    check_eq("mid_rst_pred", 64'(bus.pred_taken), 64'd0);
    sb.delete();
    n_pop = n_push;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 64'(bus.res_ready), 64'd1);
    check_eq("post_rst_flush", 64'(bus.flush), 64'd0);
    repeat (4) @(negedge clk);
    do_res(1'b1, 3'b110, 64'd1, 64'd2, 64'h2000, 64'h80, 1'b1);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    check_eq("results_seen", 64'(n_pop), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 64, operand/PC/target width.
REQ-002 Parameter BHT_DEPTH, default 16, number of 2-bit predictor entries; power of two, >= 2.
REQ-003 Parameter FLUSH_CYCLES, default 2, resolve-stall cycles after a mispredict; >= 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pred_pc  in  XLEN  fetch PC for prediction lookup.
REQ-007 pred_taken  out  1  prediction for pred_pc; combinational read of predictor state.
REQ-008 res_valid  in  1  resolve request valid.
REQ-009 res_ready  out  1  unit accepts a resolve request this cycle.
REQ-010 res_branch  in  1  request is a conditional branch; 0 = non-branch passthrough.
REQ-011 res_funct3  in  3  branch condition encoding.
REQ-012 res_a, res_b  in  XLEN each  compare operands.
REQ-013 res_pc, res_imm  in  XLEN each  branch PC and sign-extended offset.
REQ-014 res_pred_taken  in  1  prediction used by fetch for this branch.
REQ-015 out_valid  out  1  registered result valid, one-cycle pulse.
REQ-016 to_branch  out  1  resolved taken.
REQ-017 target  out  XLEN  next PC.
REQ-018 mispredict  out  1  resolved direction differs from res_pred_taken.
REQ-019 illegal_br  out  1  funct3 010/011 with res_branch=1.
REQ-020 flush  out  1  one-cycle pulse concurrent with out_valid when mispredict=1.
REQ-021 br_count, mispred_count  out  32 each  saturating statistics counters.

Function
REQ-022 Handshake: request accepted on a rising edge with res_valid=1 and res_ready=1; results on out_valid etc. in the following cycle (latency 1), held until next acceptance except out_valid/flush, which drop after one cycle.
REQ-023 Conditions: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken, illegal_br=1, no predictor update, no count.
REQ-024 res_branch=0: to_branch=0, mispredict=0, target=res_pc+4, no counts, no predictor update.
REQ-025 target = res_pc+res_imm when taken, else res_pc+4; modulo 2^XLEN wrap, no overflow flag.
REQ-026 Predictor index = pc[log2(BHT_DEPTH)+1:2]; pred_taken = entry MSB.
REQ-027 Legal branch accepted: entry at res_pc index increments (taken) or decrements (not taken), saturating at 11 and 00.
REQ-028 Simultaneous lookup and update of same index: pred_taken reflects pre-update value that cycle.
REQ-029 FSM IDLE->FLUSH on acceptance of a mispredicting branch; FLUSH counts FLUSH_CYCLES cycles beginning the cycle flush is asserted, then returns to IDLE; res_ready=1 only in IDLE.
REQ-030 br_count +1 per accepted legal branch; mispred_count +1 per mispredict; both hold at 2^32-1.

Reset
REQ-031 rst_n low: immediately and asynchronously, all outputs 0 (target 0), counters 0, FSM IDLE, all predictor entries 01 (weakly not taken); res_ready=1 from first edge after release.
REQ-032 Reset mid-FLUSH or with a pending result discards it; no flush/out_valid after release.

Structure
REQ-033 Shared package branch_pkg holds funct3 encodings, FSM state enum, predictor reset constant 2'b01 and counter width 32.
REQ-034 Predictor storage and saturating update live in sub-module bht_table (read-comb, write-sync, async reset).

Verification
REQ-035 XLEN=64: funct3=100, a=-1, b=1, pc=0x100, imm=0x20, pred=0 -> next cycle to_branch=1, target=0x120, mispredict=1, flush=1, res_ready=0 for 2 cycles.
REQ-036 funct3=110, a=-1 (0xFFFF..F), b=1 -> to_branch=0, target=pc+4; funct3=111 same operands -> to_branch=1.
REQ-037 Same PC, 3 taken resolutions after reset -> pred_taken 0, 1, 1; 4 not-taken -> saturates back to 0 after two.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC, not taken -> target=0; funct3=011 -> illegal_br=1, br_count unchanged.
REQ-039 rst_n asserted during FLUSH -> outputs 0 immediately, res_ready=1 after release, predictor entries 01.
REQ-040 Lookup and update same index same cycle -> pred_taken shows old value, new value next cycle.
